// File: rtl/snake_vga_pkg.sv
// Shared constants and state encoding for the snake game VGA drawing path.
package snake_vga_pkg;

    localparam int X_MAX = 160;
    localparam int Y_MAX = 120;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] RED   = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/vga_plot_arbiter_if.sv
// Requester-side rectangle bus plus the pixel-write port towards vga_adapter.
interface vga_plot_arbiter_if #(
    parameter int N_REQ = 3
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] rect_x;
    logic [7*N_REQ-1:0] rect_y;
    logic [8*N_REQ-1:0] rect_w;
    logic [7*N_REQ-1:0] rect_h;
    logic [3*N_REQ-1:0] rect_colour;
    logic [N_REQ-1:0]   grant;
    logic [N_REQ-1:0]   done;
    logic               busy;
    logic [7:0]         x_out;
    logic [6:0]         y_out;
    logic [2:0]         colour_out;
    logic               plot;

    modport master (
        output req, rect_x, rect_y, rect_w, rect_h, rect_colour,
        input  grant, done, busy, x_out, y_out, colour_out, plot
    );

    modport slave (
        input  req, rect_x, rect_y, rect_w, rect_h, rect_colour,
        output grant, done, busy, x_out, y_out, colour_out, plot
    );
endinterface

// File: rtl/vga_plot_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first pending requester after last_i, with wrap.
module rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    last_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IW-1:0]    idx_o,
    output logic             valid_o
);
    int cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(last_i) + k) % N_REQ;
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares the vga_adapter pixel port among rectangle-fill requesters, one pixel per clock.
module vga_plot_arbiter #(
    parameter int N_REQ = 3,
    parameter int X_MAX = snake_vga_pkg::X_MAX,
    parameter int Y_MAX = snake_vga_pkg::Y_MAX
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    vga_plot_arbiter_if.slave bus
);
    localparam int         IW    = $clog2(N_REQ);
    localparam logic [8:0] X_LIM = 9'(X_MAX);
    localparam logic [7:0] Y_LIM = 8'(Y_MAX);

    snake_vga_pkg::state_e state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d, done_q, done_d;
    logic             busy_q, busy_d, plot_q, plot_d;
    logic [7:0]       x_out_q, x_out_d;
    logic [6:0]       y_out_q, y_out_d;
    logic [2:0]       col_out_q, col_out_d;
    logic [7:0]       x0_q, x0_d, w_q, w_d, cx_q, cx_d;
    logic [6:0]       y0_q, y0_d, h_q, h_d, cy_q, cy_d;
    logic [2:0]       colour_q, colour_d;
    logic [IW-1:0]    last_q, last_d, win_q, win_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [IW-1:0]    arb_idx;
    logic             arb_valid;
    logic [8:0]       x_sum;
    logic [7:0]       y_sum;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req_i  (bus.req),
        .last_i (last_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx),
        .valid_o(arb_valid)
    );

    // Widened sums so off-screen coordinates never alias back onto the screen.
    assign x_sum = {1'b0, x0_q} + {1'b0, cx_q};
    assign y_sum = {1'b0, y0_q} + {1'b0, cy_q};

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        done_d    = '0;
        busy_d    = busy_q;
        plot_d    = 1'b0;
        x_out_d   = x_out_q;
        y_out_d   = y_out_q;
        col_out_d = col_out_q;
        x0_d      = x0_q;
        y0_d      = y0_q;
        w_d       = w_q;
        h_d       = h_q;
        colour_d  = colour_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        last_d    = last_q;
        win_d     = win_q;
        case (state_q)
            snake_vga_pkg::IDLE: begin
                if (arb_valid) begin
                    grant_d  = arb_gnt;
                    busy_d   = 1'b1;
                    win_d    = arb_idx;
                    x0_d     = bus.rect_x[8*arb_idx +: 8];
                    y0_d     = bus.rect_y[7*arb_idx +: 7];
                    w_d      = bus.rect_w[8*arb_idx +: 8];
                    h_d      = bus.rect_h[7*arb_idx +: 7];
                    colour_d = bus.rect_colour[3*arb_idx +: 3];
                    cx_d     = '0;
                    cy_d     = '0;
                    if (w_d == 8'd0 || h_d == 7'd0) begin
                        state_d = snake_vga_pkg::DONE;
                    end else begin
                        state_d = snake_vga_pkg::SCAN;
                    end
                end
            end
            snake_vga_pkg::SCAN: begin
                x_out_d   = x_sum[7:0];
                y_out_d   = y_sum[6:0];
                col_out_d = colour_q;
                plot_d    = (x_sum < X_LIM) && (y_sum < Y_LIM);
                if (cx_q == w_q - 8'd1) begin
                    cx_d = '0;
                    cy_d = cy_q + 7'd1;
                    if (cy_q == h_q - 7'd1) begin
                        state_d = snake_vga_pkg::DONE;
                    end
                end else begin
                    cx_d = cx_q + 8'd1;
                end
            end
            snake_vga_pkg::DONE: begin
                done_d[win_q] = 1'b1;
                grant_d       = '0;
                busy_d        = 1'b0;
                last_d        = win_q;
                state_d       = snake_vga_pkg::IDLE;
            end
            default: state_d = snake_vga_pkg::IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q   <= snake_vga_pkg::IDLE;
            grant_q   <= '0;
            done_q    <= '0;
            busy_q    <= 1'b0;
            plot_q    <= 1'b0;
            x_out_q   <= '0;
            y_out_q   <= '0;
            col_out_q <= '0;
            x0_q      <= '0;
            y0_q      <= '0;
            w_q       <= '0;
            h_q       <= '0;
            colour_q  <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            last_q    <= IW'(N_REQ - 1);
            win_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            plot_q    <= plot_d;
            x_out_q   <= x_out_d;
            y_out_q   <= y_out_d;
            col_out_q <= col_out_d;
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            w_q       <= w_d;
            h_q       <= h_d;
            colour_q  <= colour_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            last_q    <= last_d;
            win_q     <= win_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.done       = done_q;
    assign bus.busy       = busy_q;
    assign bus.plot       = plot_q;
    assign bus.x_out      = x_out_q;
    assign bus.y_out      = y_out_q;
    assign bus.colour_out = col_out_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed and randomized rectangle fills checked against a raster/round-robin reference model.
module tb_vga_plot_arbiter;
    localparam int N = 3;

    logic clk = 1'b0;
    logic resetn;
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_last;
    int   rx[N], ry[N], rw[N], rh[N], rc[N];
    int   np;

    always #5 clk = ~clk;

    vga_plot_arbiter_if #(.N_REQ(N)) bus ();

    vga_plot_arbiter #(.N_REQ(N), .X_MAX(160), .Y_MAX(120)) dut (
        .CLOCK_50(clk),
        .resetn  (resetn),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rect(input int i, input int x, input int y, input int w, input int h, input int c);
        rx[i] = x; ry[i] = y; rw[i] = w; rh[i] = h; rc[i] = c;
        bus.rect_x[8*i +: 8]      = 8'(x);
        bus.rect_y[7*i +: 7]      = 7'(y);
        bus.rect_w[8*i +: 8]      = 8'(w);
        bus.rect_h[7*i +: 7]      = 7'(h);
        bus.rect_colour[3*i +: 3] = 3'(c);
    endtask

    function automatic int rr_pick(input logic [N-1:0] m, input int last);
        for (int k = 1; k <= N; k++) begin
            if (m[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_grant"}, bus.grant, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_plot"}, bus.plot, 0);
        chk({tag, "_x"}, bus.x_out, 0);
        chk({tag, "_y"}, bus.y_out, 0);
        chk({tag, "_colour"}, bus.colour_out, 0);
    endtask

    // Called at a falling edge where the DUT is idle and the req lines are set up.
    task automatic serve(input bit drop, output int plots);
        int win;
        win   = rr_pick(bus.req, m_last);
        plots = 0;
        if (win < 0) return;
        @(negedge clk);
        chk("grant_start", bus.grant, 1 << win);
        chk("busy_start", bus.busy, 1);
        chk("plot_start", bus.plot, 0);
        for (int r = 0; r < rh[win]; r++) begin
            for (int c = 0; c < rw[win]; c++) begin
                int px = rx[win] + c;
                int py = ry[win] + r;
                bit vis = (px < 160) && (py < 120);
                @(negedge clk);
                chk("grant_scan", bus.grant, 1 << win);
                chk("plot", bus.plot, 32'(vis));
                if (vis) begin
                    chk("x_out", bus.x_out, px);
                    chk("y_out", bus.y_out, py);
                    chk("colour", bus.colour_out, rc[win]);
                end
                plots += int'(bus.plot);
            end
        end
        @(negedge clk);
        chk("done", bus.done, 1 << win);
        chk("grant_end", bus.grant, 0);
        chk("busy_end", bus.busy, 0);
        chk("plot_end", bus.plot, 0);
        $display("rect req%0d (%0d,%0d) %0dx%0d colour %0d: %0d plots observed",
                 win, rx[win], ry[win], rw[win], rh[win], rc[win], plots);
        m_last = win;
        if (drop) bus.req[win] = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        m_last = N - 1;
    endtask

    initial begin
        resetn  = 1'b0;
        bus.req = '0;
        for (int i = 0; i < N; i++) set_rect(i, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        resetn = 1'b1;
        m_last = N - 1;

        // Single 2x2 fill.
        set_rect(0, 80, 30, 2, 2, 3'b010);
        bus.req[0] = 1'b1;
        serve(1'b1, np);
        chk("single_plots", np, 4);

        // Full-screen clear.
        set_rect(0, 0, 0, 160, 120, 3'b000);
        bus.req[0] = 1'b1;
        serve(1'b1, np);
        chk("clear_plots", np, 19200);

        // Contention after reset, both held: expect 0,1,0,1.
        do_reset();
        set_rect(0, 5, 5, 3, 2, 3'b001);
        set_rect(1, 50, 60, 2, 2, 3'b100);
        bus.req[0] = 1'b1;
        bus.req[1] = 1'b1;
        repeat (4) serve(1'b0, np);
        bus.req = '0;

        // Clipping at the bottom-right corner.
        set_rect(1, 158, 118, 4, 4, 3'b101);
        bus.req[1] = 1'b1;
        serve(1'b1, np);
        chk("clip_plots", np, 4);

        // Zero-width rectangle.
        set_rect(2, 10, 10, 0, 5, 3'b011);
        bus.req[2] = 1'b1;
        serve(1'b1, np);
        chk("zero_plots", np, 0);

        // Reset in the middle of a 10x10 fill.
        set_rect(0, 20, 20, 10, 10, 3'b110);
        bus.req[0] = 1'b1;
        repeat (39) @(negedge clk);
        set_rect(1, 100, 100, 2, 1, 3'b111);
        bus.req[1] = 1'b1;
        resetn = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        resetn = 1'b1;
        m_last = N - 1;
        serve(1'b1, np);
        serve(1'b1, np);

        // Randomized batches of overlapping requests.
        for (int round = 0; round < 12; round++) begin
            logic [N-1:0] mask;
            int cnt;
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                if (mask[i]) begin
                    set_rect(i, $urandom_range(0, 170), $urandom_range(0, 127),
                             $urandom_range(0, 6), $urandom_range(0, 5), $urandom_range(0, 7));
                end
            end
            bus.req = mask;
            cnt = 0;
            while (bus.req != '0) begin
                serve(($urandom_range(0, 3) != 0) || (cnt >= 4), np);
                cnt++;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
